// File: rtl/aes_word_packer_pkg.sv
// Shared types for the AES word packer: control/flag structs, FSM states and block geometry.
package aes_package;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORDS_PER_BLOCK = 4;
  localparam int AES_WORD_W          = 32;
  // flags_packer_t carries the block counter at this fixed width; narrower counters are zero-extended.
  localparam int AES_BLOCK_CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } packer_state_e;

  typedef struct packed {
    logic enable;
    logic clear;
  } ctrl_packer_t;

  typedef struct packed {
    logic                           busy;
    logic [1:0]                     word_cnt;
    logic                           block_done;
    logic [AES_BLOCK_CNT_MAX_W-1:0] block_cnt;
  } flags_packer_t;

  function automatic logic [AES_WORD_W-1:0] bswap32(input logic [AES_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready stream interface with byte strobes, as used between streamer and engines.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/aes_word_packer.sv
// Packs four 32-bit stream words into one 128-bit AES block, first word in the MSBs.
// Define AES_PACKER_BYTESWAP_EN to byte-reverse each word before placement.
module aes_word_packer
  import aes_package::*;
#(
  parameter int unsigned BLOCK_CNT_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        test_mode_i,
  hwpe_stream_intf_stream.sink        word_i,
  hwpe_stream_intf_stream.source      block_o,
  input  ctrl_packer_t                ctrl_i,
  output flags_packer_t               flags_o
);

  packer_state_e                                    state_q, state_d;
  logic [1:0]                                       word_cnt_q, word_cnt_d;
  logic [BLOCK_CNT_W-1:0]                           block_cnt_q, block_cnt_d;
  logic                                             block_done_q;
  logic [AES_WORDS_PER_BLOCK-1:0][AES_WORD_W-1:0]   buf_q;
  logic [AES_WORD_W-1:0]                            word_in;
  logic                                             accept, handshake;
  logic                                             unused_inputs;

  assign unused_inputs = ^{test_mode_i, word_i.strb};

`ifdef AES_PACKER_BYTESWAP_EN
  assign word_in = bswap32(word_i.data);
`else
  assign word_in = word_i.data;
`endif

  assign word_i.ready = ctrl_i.enable & (state_q != HOLD);
  assign accept       = word_i.valid & word_i.ready;
  // Enable low freezes HOLD too, so the handshake only completes while enabled.
  assign handshake    = (state_q == HOLD) & block_o.ready & ctrl_i.enable;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    block_cnt_d = block_cnt_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FILL;
      FILL:    if (accept && word_cnt_q == 2'd3) state_d = HOLD;
      HOLD:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) word_cnt_d = word_cnt_q + 2'd1;
    if (handshake) begin
      word_cnt_d  = 2'd0;
      block_cnt_d = block_cnt_q + BLOCK_CNT_W'(1);
    end
    if (ctrl_i.clear) begin
      state_d     = IDLE;
      word_cnt_d  = 2'd0;
      block_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      word_cnt_q   <= 2'd0;
      block_cnt_q  <= '0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      block_cnt_q  <= block_cnt_d;
      block_done_q <= handshake & ~ctrl_i.clear;
    end
  end

  // One enabled register per word slot; slot k sits at block bits [127-32k -: 32].
  for (genvar k = 0; k < AES_WORDS_PER_BLOCK; k++) begin : g_slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                             buf_q[k] <= '0;
      else if (accept && word_cnt_q == 2'(k))  buf_q[k] <= word_in;
    end
    assign block_o.data[AES_BLOCK_W-1-AES_WORD_W*k -: AES_WORD_W] = buf_q[k];
  end

  assign block_o.valid = (state_q == HOLD);
  assign block_o.strb  = '1;

  assign flags_o.busy       = (state_q != IDLE);
  assign flags_o.word_cnt   = word_cnt_q;
  assign flags_o.block_done = block_done_q;
  assign flags_o.block_cnt  = AES_BLOCK_CNT_MAX_W'(block_cnt_q);

endmodule

// File: doc/aes_word_packer.md
AES_WORD_PACKER -- requirements
Module: aes_word_packer

Interface
REQ-001 SHALL have parameter BLOCK_CNT_W, default 16, width of the emitted-block counter.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port test_mode_i, input, 1, accepted and functionally unused.
REQ-005 SHALL have port word_i, hwpe_stream_intf_stream.sink, 32-bit data, the plaintext word stream from the streamer.
REQ-006 SHALL have port block_o, hwpe_stream_intf_stream.source, 128-bit data, the packed AES block stream toward the engine.
REQ-007 SHALL have port ctrl_i, input, ctrl_packer_t, with fields enable (1) and clear (1).
REQ-008 SHALL have port flags_o, output, flags_packer_t, with fields busy, word_cnt[1:0], block_done and block_cnt[BLOCK_CNT_W-1:0].

Function
REQ-009 SHALL implement an FSM with states IDLE, FILL and HOLD.
REQ-010 SHALL drive word_i.ready = ctrl_i.enable AND (state != HOLD).
REQ-011 SHALL accept a word only on a cycle where word_i.valid and word_i.ready are both high.
REQ-012 SHALL place the word accepted at word_cnt k into block bits [127-32k -: 32], so the first word lands in the MSBs (AES big-endian column order).
REQ-013 SHALL transition IDLE->FILL on the first accepted word and FILL->HOLD on the cycle the 4th word is accepted.
REQ-014 SHALL assert block_o.valid only in HOLD, exactly one cycle after the 4th word is accepted.
REQ-015 SHALL drive block_o.strb to all ones.
REQ-016 SHALL hold block_o.data and block_o.valid stable in HOLD until block_o.ready is high.
REQ-017 SHALL, on the HOLD handshake, return to IDLE, set word_cnt to 0, increment block_cnt (wrapping modulo 2^BLOCK_CNT_W), and pulse block_done high for exactly one cycle.
REQ-018 SHALL NOT accept any word in the HOLD handshake cycle; the next word is accepted one cycle later at the earliest (throughput 1 block per 5 cycles).
REQ-019 SHALL treat ctrl_i.enable low as a freeze: word_i.ready low, state and buffer held, and an already valid block_o kept valid.
REQ-020 SHALL, on ctrl_i.clear high (synchronous, priority over every other event including a simultaneous handshake), go to IDLE, set word_cnt, block_cnt and block_valid to 0, and discard the partial block without counting it.
REQ-021 SHALL drive busy high whenever state != IDLE.
REQ-022 SHALL ignore word_i.strb.

Reset
REQ-023 SHALL, while rst_ni is low and independent of clk_i, force state to IDLE, the data buffer, word_cnt, block_cnt and block_done to 0, and block_o.valid to 0.
REQ-024 SHALL, when reset is asserted mid-block, discard the partial block and resume with word_cnt 0 after release.

Configuration
REQ-025 SHALL, when macro AES_PACKER_BYTESWAP_EN is defined, byte-reverse each accepted word (byte0<->byte3, byte1<->byte2) before placement.
REQ-026 SHALL, when AES_PACKER_BYTESWAP_EN is undefined, place words unmodified; timing is identical in both builds.

Structure
REQ-027 SHALL take ctrl_packer_t, flags_packer_t and the FSM state enum from aes_package.
REQ-028 SHALL define AES_BLOCK_W = 128 and AES_WORDS_PER_BLOCK = 4 in aes_package.
REQ-029 SHALL be a single module with no sub-modules; word placement is a decoded register-enable per word slot.

Verification
REQ-030 SHALL be covered by: enable=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, block_o.ready=1 -> block_o.data = 0x00112233_44556677_8899AABB_CCDDEEFF one cycle after the 4th word, block_cnt = 1, block_done pulse one cycle (byte-swap build: 0x33221100_77665544_BBAA9988_FFEEDDCC).
REQ-031 SHALL be covered by: block_o.ready=0 for 10 cycles in HOLD with word_i.valid=1 -> word_i.ready=0, data stable; ready=1 -> one handshake, IDLE next cycle.
REQ-032 SHALL be covered by: clear after 2 words, then 4 new words -> the emitted block contains only the new words, block_cnt = 1.
REQ-033 SHALL be covered by: rst_ni low after 3 words -> valid=0, word_cnt=0 asynchronously; 4 words after release -> one correct block.
REQ-034 SHALL be covered by: BLOCK_CNT_W=2, 5 blocks -> block_cnt sequence 1, 2, 3, 0, 1.
REQ-035 SHALL be covered by: enable dropped during FILL at word_cnt=2 for 3 cycles -> no acceptance, buffer held, completes correctly after enable returns.
